processor_run_ctrl: RTL and testbench



---
 rtl/processor_ctrl_pkg.sv | 20 ++
 rtl/run_ctrl_cycle_counter.sv | 46 ++++
 rtl/processor_run_ctrl.sv | 130 +++++++++++++
 tb/tb_processor_run_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_ctrl_pkg.sv
// Shared state encodings and defaults for the processor run/step controller.
package processor_ctrl_pkg;

  localparam int CC_WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STEP    = 3'd2,
    ST_PAUSED  = 3'd3,
    ST_HALTED  = 3'd4,
    ST_TIMEOUT = 3'd5
  } run_state_t;

  // The core is enabled exactly while the controller sits in RUN or STEP.
  function automatic logic is_enabled(input run_state_t s);
    return (s == ST_RUN) || (s == ST_STEP);
  endfunction

endpackage

// File: rtl/run_ctrl_cycle_counter.sv
// Saturating enabled-cycle counter with synchronous clear and NCMP equality
// compares against the count value this edge would load.
module run_ctrl_cycle_counter
  import processor_ctrl_pkg::*;
#(
  parameter int WIDTH = CC_WIDTH_DEFAULT,
  parameter int NCMP  = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_clear,
  input  logic                        i_inc,
  input  logic [NCMP-1:0][WIDTH-1:0]  i_cmp_val,
  output logic [WIDTH-1:0]            o_count,
  output logic [NCMP-1:0]             o_cmp_eq
);

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_inc;

  // Holding at all-ones keeps the count from wrapping on very long runs.
  always_comb begin
    w_count_inc = r_count;
    if (i_inc && (r_count != '1)) begin
      w_count_inc = r_count + WIDTH'(1);
    end
  end

  always_comb begin
    o_cmp_eq = '0;
    for (int k = 0; k < NCMP; k++) begin
      o_cmp_eq[k] = (w_count_inc == i_cmp_val[k]);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_inc;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/processor_run_ctrl.sv
// Run/step sequencer driving the processor core enable, with halt detection and watchdog.
// Optional RUN_CTRL_BREAKPOINT_EN adds a cycle-count breakpoint that pauses a run.
module processor_run_ctrl
  import processor_ctrl_pkg::*;
#(
  parameter int                  CC_WIDTH   = CC_WIDTH_DEFAULT,
  parameter logic [CC_WIDTH-1:0] WDOG_LIMIT = CC_WIDTH'(1000)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic                stop,
  input  logic                proc_halt,
`ifdef RUN_CTRL_BREAKPOINT_EN
  input  logic [CC_WIDTH-1:0] bp_cycle,
  input  logic                bp_valid,
`endif
  output logic                proc_en,
  output logic [CC_WIDTH-1:0] cycle_cnt,
  output logic [2:0]          state,
  output logic                done,
  output logic                timeout
);

`ifdef RUN_CTRL_BREAKPOINT_EN
  localparam int NCMP = 2;
`else
  localparam int NCMP = 1;
`endif

  run_state_t                    r_state;
  run_state_t                    w_next;
  logic                          r_proc_en;
  logic                          w_clear;
  logic [NCMP-1:0][CC_WIDTH-1:0] w_cmp_val;
  logic [NCMP-1:0]               w_cmp_eq;
  logic [CC_WIDTH-1:0]           w_count;
  logic                          w_wdog_hit;
  logic                          w_bp_hit;

  // Compare slot 0 is the watchdog; slot 1 (when present) is the breakpoint.
  always_comb begin
    w_cmp_val    = '0;
    w_cmp_val[0] = WDOG_LIMIT;
`ifdef RUN_CTRL_BREAKPOINT_EN
    w_cmp_val[1] = bp_cycle;
`endif
  end

  assign w_wdog_hit = (WDOG_LIMIT != '0) && w_cmp_eq[0];
`ifdef RUN_CTRL_BREAKPOINT_EN
  assign w_bp_hit   = bp_valid && w_cmp_eq[1];
`else
  assign w_bp_hit   = 1'b0;
`endif

  run_ctrl_cycle_counter #(
    .WIDTH (CC_WIDTH),
    .NCMP  (NCMP)
  ) u_counter (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_clear   (w_clear),
    .i_inc     (r_proc_en),
    .i_cmp_val (w_cmp_val),
    .o_count   (w_count),
    .o_cmp_eq  (w_cmp_eq)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_proc_en <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_proc_en <= is_enabled(w_next);
    end
  end

  // Command priority is stop > start > step; a halting core beats everything in RUN.
  always_comb begin
    w_next  = r_state;
    w_clear = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!stop) begin
          if (start) begin
            w_next  = ST_RUN;
            w_clear = 1'b1;
          end else if (step) begin
            w_next = ST_STEP;
          end
        end
      end
      ST_RUN: begin
        if (proc_halt)       w_next = ST_HALTED;
        else if (w_bp_hit)   w_next = ST_PAUSED;
        else if (stop)       w_next = ST_PAUSED;
        else if (w_wdog_hit) w_next = ST_TIMEOUT;
      end
      ST_STEP: begin
        w_next = proc_halt ? ST_HALTED : ST_PAUSED;
      end
      ST_PAUSED: begin
        if (stop)       w_next = ST_IDLE;
        else if (start) w_next = ST_RUN;
        else if (step)  w_next = ST_STEP;
      end
      ST_HALTED, ST_TIMEOUT: begin
        if (stop) begin
          w_next = ST_IDLE;
        end else if (start) begin
          w_next  = ST_RUN;
          w_clear = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    proc_en   = r_proc_en;
    cycle_cnt = w_count;
    state     = r_state;
    done      = (r_state == ST_HALTED);
    timeout   = (r_state == ST_TIMEOUT);
  end

endmodule

// File: tb/tb_processor_run_ctrl.sv
// Self-checking bench for processor_run_ctrl: directed scenarios then random commands
// compared against a cycle-level reference model (WDOG_LIMIT overridden to 20).
module tb_processor_run_ctrl;

  localparam int CCW       = 16;
  localparam int WDOG      = 20;
  localparam int CNT_MAX   = 65535;
  localparam int S_IDLE    = 0;
  localparam int S_RUN     = 1;
  localparam int S_STEP    = 2;
  localparam int S_PAUSED  = 3;
  localparam int S_HALTED  = 4;
  localparam int S_TIMEOUT = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic           step;
  logic           stop;
  logic           proc_halt;
  logic [CCW-1:0] bpCycle;
  logic           bpValid;
  logic           proc_en;
  logic [CCW-1:0] cycle_cnt;
  logic [2:0]     state;
  logic           done;
  logic           timeout;

  int checkCount;
  int passCount;
  int mState;
  int mCnt;
  bit mEn;

  processor_run_ctrl #(
    .CC_WIDTH   (CCW),
    .WDOG_LIMIT (16'd20)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step      (step),
    .stop      (stop),
    .proc_halt (proc_halt),
`ifdef RUN_CTRL_BREAKPOINT_EN
    .bp_cycle  (bpCycle),
    .bp_valid  (bpValid),
`endif
    .proc_en   (proc_en),
    .cycle_cnt (cycle_cnt),
    .state     (state),
    .done      (done),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "[TB] simulation time limit exceeded");
  end

  // Reference model: advances one clock edge from the command rules.
  task automatic modelEdge(input bit r, input bit st, input bit sp, input bit so, input bit h);
    int nxt;
    int incd;
    bit clr;
    if (r) begin
      mState = S_IDLE;
      mCnt   = 0;
      mEn    = 0;
    end else begin
      incd = mCnt + ((mEn && mCnt < CNT_MAX) ? 1 : 0);
      nxt  = mState;
      clr  = 0;
      case (mState)
        S_IDLE: begin
          if (so) nxt = S_IDLE;
          else if (st) begin nxt = S_RUN; clr = 1; end
          else if (sp) nxt = S_STEP;
        end
        S_RUN: begin
          if (h) nxt = S_HALTED;
          else if (bpValid && incd == int'(bpCycle)) nxt = S_PAUSED;
          else if (so) nxt = S_PAUSED;
          else if (WDOG != 0 && incd == WDOG) nxt = S_TIMEOUT;
        end
        S_STEP: nxt = h ? S_HALTED : S_PAUSED;
        S_PAUSED: begin
          if (so) nxt = S_IDLE;
          else if (st) nxt = S_RUN;
          else if (sp) nxt = S_STEP;
        end
        default: begin
          if (so) nxt = S_IDLE;
          else if (st) begin nxt = S_RUN; clr = 1; end
        end
      endcase
      mCnt   = clr ? 0 : incd;
      mState = nxt;
      mEn    = (nxt == S_RUN) || (nxt == S_STEP);
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, ".proc_en"}, 32'(proc_en), 32'(mEn));
    checkValue({tag, ".cycle_cnt"}, 32'(cycle_cnt), 32'(mCnt));
    checkValue({tag, ".state"}, 32'(state), 32'(mState));
    checkValue({tag, ".done"}, 32'(done), 32'(mState == S_HALTED));
    checkValue({tag, ".timeout"}, 32'(timeout), 32'(mState == S_TIMEOUT));
  endtask

  task automatic applyStimulus(input string tag, input bit r, input bit st, input bit sp,
                               input bit so, input bit h);
    rst       = r;
    start     = st;
    step      = sp;
    stop      = so;
    proc_halt = h;
    @(posedge clk);
    modelEdge(r, st, sp, so, h);
    #1;
    checkOutput(tag);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    mState     = S_IDLE;
    mCnt       = 0;
    mEn        = 0;
    bpValid    = 1'b0;
    bpCycle    = '0;
    rst = 1'b1; start = 1'b0; step = 1'b0; stop = 1'b0; proc_halt = 1'b0;

    repeat (3) applyStimulus("reset", 1, 0, 0, 0, 0);
    checkValue("reset.state", 32'(state), 0);
    checkValue("reset.proc_en", 32'(proc_en), 0);
    checkValue("reset.cycle_cnt", 32'(cycle_cnt), 0);

    // Run until the core halts after ten enabled cycles.
    applyStimulus("halt10", 0, 1, 0, 0, 0);
    repeat (9) applyStimulus("halt10", 0, 0, 0, 0, 0);
    checkValue("halt10.en_before", 32'(proc_en), 1);
    applyStimulus("halt10", 0, 0, 0, 0, 1);
    checkValue("halt10.state", 32'(state), S_HALTED);
    checkValue("halt10.done", 32'(done), 1);
    checkValue("halt10.cycle_cnt", 32'(cycle_cnt), 10);
    checkValue("halt10.proc_en", 32'(proc_en), 0);
    applyStimulus("halt10.step_ignored", 0, 0, 1, 0, 0);
    checkValue("halt10.sticky", 32'(state), S_HALTED);

    // Three single steps from a fresh reset.
    applyStimulus("steps", 1, 0, 0, 0, 0);
    repeat (3) begin
      applyStimulus("steps", 0, 0, 1, 0, 0);
      checkValue("steps.pulse", 32'(proc_en), 1);
      repeat (3) begin
        applyStimulus("steps", 0, 0, 0, 0, 0);
        checkValue("steps.after", 32'(proc_en), 0);
        checkValue("steps.paused", 32'(state), S_PAUSED);
      end
    end
    checkValue("steps.cycle_cnt", 32'(cycle_cnt), 3);

    // Watchdog expiry after twenty enabled cycles, then restart clears the count.
    applyStimulus("wdog", 1, 0, 0, 0, 0);
    applyStimulus("wdog", 0, 1, 0, 0, 0);
    repeat (19) applyStimulus("wdog", 0, 0, 0, 0, 0);
    checkValue("wdog.still_run", 32'(state), S_RUN);
    applyStimulus("wdog", 0, 0, 0, 0, 0);
    checkValue("wdog.timeout", 32'(timeout), 1);
    checkValue("wdog.cycle_cnt", 32'(cycle_cnt), 20);
    checkValue("wdog.proc_en", 32'(proc_en), 0);
    applyStimulus("wdog.restart", 0, 1, 0, 0, 0);
    checkValue("wdog.restart_cnt", 32'(cycle_cnt), 0);
    checkValue("wdog.restart_state", 32'(state), S_RUN);
    applyStimulus("wdog.stop", 0, 0, 0, 1, 0);

    // Pause at five, resume, halt at twelve.
    applyStimulus("pause", 1, 0, 0, 0, 0);
    applyStimulus("pause", 0, 1, 0, 0, 0);
    repeat (4) applyStimulus("pause", 0, 0, 0, 0, 0);
    applyStimulus("pause", 0, 0, 0, 1, 0);
    checkValue("pause.state", 32'(state), S_PAUSED);
    checkValue("pause.cycle_cnt", 32'(cycle_cnt), 5);
    applyStimulus("pause.resume", 0, 1, 0, 0, 0);
    checkValue("pause.resume_cnt", 32'(cycle_cnt), 5);
    repeat (6) applyStimulus("pause", 0, 0, 0, 0, 0);
    applyStimulus("pause", 0, 0, 0, 0, 1);
    checkValue("pause.halted", 32'(state), S_HALTED);
    checkValue("pause.final_cnt", 32'(cycle_cnt), 12);

    // Simultaneous commands from IDLE, then reset in the middle of a run.
    applyStimulus("prio", 1, 0, 0, 0, 0);
    applyStimulus("prio", 0, 1, 1, 1, 0);
    checkValue("prio.state", 32'(state), S_IDLE);
    checkValue("prio.proc_en", 32'(proc_en), 0);
    applyStimulus("midrst", 0, 1, 0, 0, 0);
    repeat (3) applyStimulus("midrst", 0, 0, 0, 0, 0);
    applyStimulus("midrst", 1, 0, 0, 0, 0);
    checkValue("midrst.proc_en", 32'(proc_en), 0);
    checkValue("midrst.cycle_cnt", 32'(cycle_cnt), 0);

`ifdef RUN_CTRL_BREAKPOINT_EN
    bpValid = 1'b1;
    bpCycle = 16'd7;
    applyStimulus("bp", 0, 1, 0, 0, 0);
    repeat (7) applyStimulus("bp", 0, 0, 0, 0, 0);
    checkValue("bp.state", 32'(state), S_PAUSED);
    checkValue("bp.cycle_cnt", 32'(cycle_cnt), 7);
    applyStimulus("bp.resume", 0, 1, 0, 0, 0);
    repeat (3) applyStimulus("bp", 0, 0, 0, 0, 0);
    applyStimulus("bp", 0, 0, 0, 0, 1);
    checkValue("bp.halted", 32'(state), S_HALTED);
    checkValue("bp.final_cnt", 32'(cycle_cnt), 11);
    bpValid = 1'b0;
`endif

    // Random command traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      applyStimulus("random",
                    $urandom_range(0, 63) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 7) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 14) == 0);
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
